// File: rtl/morse_encode_if.sv
// Handshake and data bundle between a Morse encoder and its user.
// The master drives the request; the slave (the encoder) returns the stream.
interface morse_encode_if #(
  parameter int N_CHAR = 5
);
  logic                  start;
  logic [7*N_CHAR-1:0]   in_text;
  logic [16*N_CHAR-1:0]  out_bits;
  logic                  valid;
  logic                  busy;
  logic                  err;

  modport master (output start, in_text, input out_bits, valid, busy, err);
  modport slave  (input start, in_text, output out_bits, valid, busy, err);
endinterface

// File: rtl/morse_encode.sv
// Morse encoder: turns N_CHAR ASCII capitals into an on/off bit stream.
// dot = "10", dash = "1110", letter end = "00", packed MSB-first from the top
// of out_bits. One symbol is written per cycle, plus one cycle per letter gap.
module morse_encode #(
  parameter int N_CHAR = 5
) (
  input  logic          clk,
  input  logic          rst,
  morse_encode_if.slave bus
);
  localparam int TW = 7 * N_CHAR;
  localparam int SW = 16 * N_CHAR;
  localparam int PW = $clog2(SW + 1);
  localparam int IW = (N_CHAR > 1) ? $clog2(N_CHAR) : 1;

  typedef enum logic [1:0] {IDLE, SYM, GAP, DONE} state_t;

  state_t         state;
  logic [TW-1:0]  text;      // latched text, shifted so the current letter sits on top
  logic [SW-1:0]  out_bits;
  logic           valid;
  logic           busy;
  logic           err;
  logic [PW-1:0]  ptr;       // bit offset from the MSB of the stream
  logic [IW-1:0]  idx;       // current character index
  logic [1:0]     sym;       // symbol index within the current letter

  logic [6:0]     cur_char;
  logic [2:0]     cur_len;
  logic [3:0]     cur_pat;
  logic           cur_dash;
  logic [PW-1:0]  sym_width;
  logic [SW-1:0]  sym_mask;
  logic           any_bad;

  // Letter table: {symbol count, pattern}; pattern is left-aligned, 1 = dash.
  function automatic logic [6:0] morse_lut(input logic [6:0] c);
    case (c)
      7'h41: morse_lut = {3'd2, 4'b0100}; // A .-
      7'h42: morse_lut = {3'd4, 4'b1000}; // B -...
      7'h43: morse_lut = {3'd4, 4'b1010}; // C -.-.
      7'h44: morse_lut = {3'd3, 4'b1000}; // D -..
      7'h45: morse_lut = {3'd1, 4'b0000}; // E .
      7'h46: morse_lut = {3'd4, 4'b0010}; // F ..-.
      7'h47: morse_lut = {3'd3, 4'b1100}; // G --.
      7'h48: morse_lut = {3'd4, 4'b0000}; // H ....
      7'h49: morse_lut = {3'd2, 4'b0000}; // I ..
      7'h4A: morse_lut = {3'd4, 4'b0111}; // J .---
      7'h4B: morse_lut = {3'd3, 4'b1010}; // K -.-
      7'h4C: morse_lut = {3'd4, 4'b0100}; // L .-..
      7'h4D: morse_lut = {3'd2, 4'b1100}; // M --
      7'h4E: morse_lut = {3'd2, 4'b1000}; // N -.
      7'h4F: morse_lut = {3'd3, 4'b1110}; // O ---
      7'h50: morse_lut = {3'd4, 4'b0110}; // P .--.
      7'h51: morse_lut = {3'd4, 4'b1101}; // Q --.-
      7'h52: morse_lut = {3'd3, 4'b0100}; // R .-.
      7'h53: morse_lut = {3'd3, 4'b0000}; // S ...
      7'h54: morse_lut = {3'd1, 4'b1000}; // T -
      7'h55: morse_lut = {3'd3, 4'b0010}; // U ..-
      7'h56: morse_lut = {3'd4, 4'b0001}; // V ...-
      7'h57: morse_lut = {3'd3, 4'b0110}; // W .--
      7'h58: morse_lut = {3'd4, 4'b1001}; // X -..-
      7'h59: morse_lut = {3'd4, 4'b1011}; // Y -.--
      7'h5A: morse_lut = {3'd4, 4'b1100}; // Z --..
      default: morse_lut = 7'd0;
    endcase
  endfunction

  // Decode the current symbol and build the mask of '1' bits it sets at ptr.
  always_comb begin
    cur_char  = text[TW-1 -: 7];
    {cur_len, cur_pat} = morse_lut(cur_char);
    cur_dash  = cur_pat[2'd3 - sym];
    sym_width = cur_dash ? PW'(4) : PW'(2);
    sym_mask  = '0;
    for (int i = 0; i < SW; i++) begin
      sym_mask[SW-1-i] = (i >= int'(ptr)) && (i < int'(ptr) + (cur_dash ? 3 : 1));
    end
  end

  // Flag any character of the incoming text outside 'A'..'Z'.
  always_comb begin
    any_bad = 1'b0;
    for (int k = 0; k < N_CHAR; k++) begin
      if (bus.in_text[7*k +: 7] < 7'h41 || bus.in_text[7*k +: 7] > 7'h5A) begin
        any_bad = 1'b1;
      end
    end
  end

  // Encoder FSM with registered outputs; reset aborts any encode in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      text     <= '0;
      out_bits <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      ptr      <= '0;
      idx      <= '0;
      sym      <= 2'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            text     <= bus.in_text;
            out_bits <= '0;
            ptr      <= '0;
            idx      <= '0;
            sym      <= 2'd0;
            if (any_bad) begin
              state <= DONE;
              valid <= 1'b1;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= SYM;
              valid <= 1'b0;
              err   <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        SYM: begin
          out_bits <= out_bits | sym_mask;
          ptr      <= ptr + sym_width;
          if (3'(sym) + 3'd1 == cur_len) begin
            sym   <= 2'd0;
            state <= GAP;
          end else begin
            sym <= sym + 2'd1;
          end
        end
        GAP: begin
          // The letter-end zeros are already present since out_bits starts cleared.
          ptr <= ptr + PW'(2);
          sym <= 2'd0;
          if (idx == IW'(N_CHAR - 1)) begin
            state <= DONE;
            valid <= 1'b1;
            busy  <= 1'b0;
          end else begin
            idx   <= idx + IW'(1);
            text  <= text << 7;
            state <= SYM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_bits = out_bits;
  assign bus.valid    = valid;
  assign bus.busy     = busy;
  assign bus.err      = err;
endmodule

// File: tb/tb_morse_encode.sv
// Directed bench for morse_encode: fixed vectors, abort/ignore cases and
// random texts round-tripped through an independent string-table decoder.
module tb_morse_encode;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  morse_encode_if #(.N_CHAR(5)) bus ();
  morse_encode #(.N_CHAR(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  string morse_tbl [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                            "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                            "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                            "-.--", "--.."};

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] pack5(input string s);
    logic [34:0] r;
    r = '0;
    for (int k = 0; k < 5; k++) r[7*(4-k) +: 7] = s[k][6:0];
    return r;
  endfunction

  function automatic logic [6:0] lookup(input string code);
    logic [6:0] r;
    r = 7'h3F;
    for (int k = 0; k < 26; k++) if (morse_tbl[k] == code) r = 7'(7'h41 + k);
    return r;
  endfunction

  function automatic logic [34:0] decode(input logic [79:0] b);
    logic [34:0] r;
    string cur;
    int i, n, run;
    r = '0; cur = ""; i = 0; n = 0;
    while (i < 80) begin
      run = 0;
      while (i < 80 && b[79-i]) begin run++; i++; end
      if (run == 1) cur = {cur, "."};
      else if (run == 3) cur = {cur, "-"};
      else cur = {cur, "?"};
      run = 0;
      while (i < 80 && !b[79-i]) begin run++; i++; end
      if (run != 1) begin
        if (n < 5) r[7*(4-n) +: 7] = lookup(cur);
        n++;
        cur = "";
      end
    end
    return r;
  endfunction

  // Start an encode and count edges until valid (lat) and samples with busy.
  task automatic run_encode(input logic [34:0] t, output int lat, output int busy_cyc);
    @(negedge clk);
    bus.in_text = t;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    while (!bus.valid && lat < 200) begin
      busy_cyc += int'(bus.busy);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bcy, exp_lat, ch;
    logic [34:0] txt;

    bus.start = 1'b0;
    bus.in_text = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_bits", bus.out_bits, 80'h0);
    check("reset_flags", {77'h0, bus.valid, bus.busy, bus.err}, 80'h0);

    // Start accepted on the first edge after reset release.
    @(negedge clk);
    rst = 1'b0;
    bus.in_text = pack5("EEEEE");
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("first_start_busy", {79'h0, bus.busy}, 80'h1);
    lat = 0; bcy = 0;
    while (!bus.valid && lat < 200) begin
      bcy += int'(bus.busy);
      @(posedge clk); #1;
      lat++;
    end
    check("eeeee_latency", 80'(lat), 80'd10);
    check("eeeee_busy_cycles", 80'(bcy), 80'd10);
    check("eeeee_bits", bus.out_bits, 80'h88888000000000000000);
    check("eeeee_err_busy", {78'h0, bus.err, bus.busy}, 80'h0);
    repeat (3) @(posedge clk);
    #1;
    check("eeeee_hold", {bus.out_bits[79:1], bus.valid}, {79'h44444000000000000000, 1'b1});

    run_encode(pack5("TEEEE"), lat, bcy);
    check("teeee_latency", 80'(lat), 80'd10);
    check("teeee_bits", bus.out_bits, 80'hE2222000000000000000);

    run_encode(pack5("QQQQQ"), lat, bcy);
    check("qqqqq_latency", 80'(lat), 80'd25);
    check("qqqqq_bits", bus.out_bits, 80'hEEB8EEB8EEB8EEB8EEB8);
    check("qqqqq_err", {79'h0, bus.err}, 80'h0);

    run_encode(pack5("ABcDE"), lat, bcy);
    check("invalid_latency", 80'(lat), 80'd0);
    check("invalid_err_valid", {78'h0, bus.err, bus.valid}, 80'h3);
    check("invalid_bits", bus.out_bits, 80'h0);
    run_encode(pack5("EEEEE"), lat, bcy);
    check("after_invalid_err", {79'h0, bus.err}, 80'h0);
    check("after_invalid_bits", bus.out_bits, 80'h88888000000000000000);

    // Start while busy is ignored; the original text completes.
    @(negedge clk);
    bus.in_text = pack5("TEEEE");
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.in_text = pack5("QQQQQ");
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 4;
    while (!bus.valid && lat < 200) begin @(posedge clk); #1; lat++; end
    check("ignored_start_latency", 80'(lat), 80'd10);
    check("ignored_start_bits", bus.out_bits, 80'hE2222000000000000000);

    // Abort a long encode with reset.
    @(negedge clk);
    bus.in_text = pack5("QQQQQ");
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.in_text = pack5("EEEEE");
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("abort_busy_after_ignored", {79'h0, bus.busy}, 80'h1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_out_bits", bus.out_bits, 80'h0);
    check("abort_flags", {77'h0, bus.valid, bus.busy, bus.err}, 80'h0);
    @(negedge clk);
    rst = 1'b0;
    run_encode(pack5("TEEEE"), lat, bcy);
    check("post_abort_latency", 80'(lat), 80'd10);
    check("post_abort_bits", bus.out_bits, 80'hE2222000000000000000);

    // Random texts: decoder round trip and latency.
    for (int r = 0; r < 6; r++) begin
      txt = '0;
      exp_lat = 0;
      for (int k = 0; k < 5; k++) begin
        ch = int'($urandom_range(0, 25));
        txt[7*(4-k) +: 7] = 7'(7'h41 + ch);
        exp_lat += morse_tbl[ch].len() + 1;
      end
      run_encode(txt, lat, bcy);
      check("random_roundtrip", 80'(decode(bus.out_bits)), 80'(txt));
      check("random_latency", 80'(lat), 80'(exp_lat));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/morse_encode.md
MORSE_ENCODE -- requirements
Module: morse_encode

Interface
REQ-001 Parameter N_CHAR, default 5: number of characters per message; text width 7*N_CHAR, stream width 16*N_CHAR.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request to encode in_text; sampled on the rising edge of clk.
REQ-005 in_text  input  7*N_CHAR  ASCII characters; first character in the most significant 7 bits ([34:28] at default).
REQ-006 out_bits  output  16*N_CHAR  Morse bit stream, MSB first, left-aligned, zero-padded.
REQ-007 valid  output  1  out_bits complete and stable.
REQ-008 busy  output  1  encoding in progress; start ignored.
REQ-009 err  output  1  last accepted in_text held a character outside 'A'..'Z' (0x41..0x5A).

Function
REQ-010 Symbol coding SHALL be: dot = "10" (2 bits), dash = "1110" (4 bits), letter end = "00" (2 bits); bits written MSB-first, starting at out_bits MSB.
REQ-011 Letter patterns SHALL be International Morse for A..Z, 1 to 4 symbols per letter; the longest letter (3 dashes + 1 dot, e.g. Q, J, Y) = 16 bits incl. letter end, so the stream never exceeds 16*N_CHAR bits.
REQ-012 FSM states SHALL be IDLE, SYM, GAP, DONE.
REQ-013 IDLE or DONE with start=1: latch in_text, clear out_bits, valid=0, err=0, write pointer=0, character index=0; next state SYM, or DONE with err=1 if any character is invalid.
REQ-014 SYM: each cycle write one symbol of the current letter at the write pointer, advance the pointer by 2 or 4, and go to GAP after the letter's last symbol.
REQ-015 GAP: write "00", advance pointer by 2; if the character index = N_CHAR-1 go to DONE, else increment the index and return to SYM.
REQ-016 Latency SHALL be sum over letters of (symbols+1) cycles from the start-accept edge to the first cycle with valid=1; invalid input gives valid=1 one cycle after accept.
REQ-017 DONE: valid=1, busy=0, out_bits held until the next accepted start or rst.
REQ-018 busy SHALL be 1 exactly in SYM and GAP; start while busy SHALL be ignored with no state change.
REQ-019 With err=1, out_bits SHALL be all zeros.
REQ-020 Bits beyond the final write pointer SHALL be 0.
REQ-021 The pointer reaching exactly 16*N_CHAR on the final GAP SHALL be legal, with no wrap and no write outside out_bits.
REQ-022 For any valid in_text, feeding out_bits to the team's Morse decoder SHALL reproduce in_text.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, out_bits=0, valid=0, busy=0, err=0, pointer=0, index=0.
REQ-024 rst SHALL take priority over start and SHALL abort an encode in progress, with no partial output retained.
REQ-025 The first start is accepted on the first edge after rst deasserts.

Verification
REQ-026 in_text="EEEEE", start 1 cycle -> busy 10 cycles; valid=1 on the 10th edge after accept; out_bits=80'h88888000000000000000; err=0.
REQ-027 in_text="TEEEE" -> 10 cycles; out_bits=80'hE2222000000000000000.
REQ-028 in_text="QQQQQ" (full-width boundary) -> 25 cycles; out_bits=80'hEEB8EEB8EEB8EEB8EEB8, no wrap or overflow.
REQ-029 in_text="ABcDE" (0x63) -> next cycle valid=1, err=1, out_bits=0; a following start with "EEEEE" clears err and encodes normally.
REQ-030 Start "QQQQQ", pulse start with "EEEEE" at cycle 5 (ignored), assert rst at cycle 12 -> all outputs 0 and state IDLE; a new start with "TEEEE" -> 80'hE2222000000000000000.
REQ-031 Random valid 5-letter texts -> decoder round-trip equals input, and latency equals sum(symbols+1).
